// File: rtl/battle_pkg.sv
// Shared definitions for the naval-battle board controller: FSM states,
// last-action status codes and width helpers.
package battle_pkg;

  typedef enum logic [1:0] {
    ST_PLACE  = 2'd0,
    ST_ATTACK = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

  localparam logic [2:0] STAT_IDLE    = 3'b000;
  localparam logic [2:0] STAT_PLACED  = 3'b001;
  localparam logic [2:0] STAT_HIT     = 3'b010;
  localparam logic [2:0] STAT_MISS    = 3'b011;
  localparam logic [2:0] STAT_REPEAT  = 3'b100;
  localparam logic [2:0] STAT_INVALID = 3'b101;
  localparam logic [2:0] STAT_WIN     = 3'b110;
  localparam logic [2:0] STAT_LOSE    = 3'b111;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..rows*cols inclusive.
  function automatic int count_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/battle_scan_div.sv
// Column scan timer: each column stays selected for SCAN_DIV clocks, then the
// scan moves to the next column, wrapping after the last one.
module battle_scan_div
  import battle_pkg::*;
#(
  parameter int COLS     = 7,
  parameter int SCAN_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     clr,
  output logic [idx_w(COLS)-1:0]   col_next,
  output logic [COLS-1:0]          col_sel
);

  localparam int CW = idx_w(COLS);
  localparam int DW = idx_w(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [DW-1:0]   div_q;
  logic [DW-1:0]   div_n;
  logic [CW-1:0]   col_q;
  logic [COLS-1:0] sel_n;

  // col_next is published so the owner can register row data for the same edge.
  always_comb begin
    div_n    = div_q + 1'b1;
    col_next = col_q;
    if (div_q == DIV_LAST) begin
      div_n    = '0;
      col_next = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
    sel_n           = '0;
    sel_n[col_next] = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_q   <= '0;
      col_q   <= '0;
      col_sel <= COLS'(1);
    end else begin
      div_q   <= div_n;
      col_q   <= col_next;
      col_sel <= sel_n;
    end
  end

endmodule

// File: rtl/battle_board_scan_ctrl.sv
// Naval-battle board: ship/attack maps, place/attack/over game flow driven by
// a confirm button, and column-multiplexed LED matrix output.
module battle_board_scan_ctrl
  import battle_pkg::*;
#(
  parameter int ROWS        = 5,
  parameter int COLS        = 7,
  parameter int SCAN_DIV    = 1000,
  parameter int MAX_ATTACKS = 15
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            mode,
  input  logic [idx_w(ROWS)-1:0]          coord_row,
  input  logic [idx_w(COLS)-1:0]          coord_col,
  input  logic                            btn_confirm,
  input  logic                            btn_clear,
  output logic [ROWS-1:0]                 led_row,
  output logic [COLS-1:0]                 led_col,
  output logic [2:0]                      status,
  output logic [count_w(ROWS,COLS)-1:0]   hit_count,
  output logic [count_w(ROWS,COLS)-1:0]   attack_count,
  output logic [count_w(ROWS,COLS)-1:0]   ship_count,
  output logic                            game_over
);

  localparam int CW = idx_w(COLS);
  localparam int AW = count_w(ROWS, COLS);
  localparam logic [AW-1:0] CELLS   = AW'(ROWS * COLS);
  localparam logic [AW-1:0] MAX_ATK = AW'(MAX_ATTACKS);

  state_e                    state, state_n;
  logic [ROWS-1:0][COLS-1:0] ship_map, ship_map_n;
  logic [ROWS-1:0][COLS-1:0] atk_map, atk_map_n;
  logic [ROWS-1:0][COLS-1:0] shown_n;
  logic [2:0]                status_n;
  logic [AW-1:0]             hit_n, atk_n, ship_n;
  logic [ROWS-1:0]           led_row_n;
  logic [CW-1:0]             scan_col_n;
  logic                      confirm_prev;
  logic                      fire;
  logic                      coord_ok;

  battle_scan_div #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .clr      (clr),
    .col_next (scan_col_n),
    .col_sel  (led_col)
  );

  assign fire      = btn_confirm & ~confirm_prev;
  assign coord_ok  = (int'(coord_row) < ROWS) && (int'(coord_col) < COLS);
  assign game_over = (state == ST_OVER);

  always_comb begin
    state_n    = state;
    ship_map_n = ship_map;
    atk_map_n  = atk_map;
    status_n   = status;
    hit_n      = hit_count;
    atk_n      = attack_count;
    ship_n     = ship_count;
    if (btn_clear) begin
      state_n    = ST_PLACE;
      ship_map_n = '0;
      atk_map_n  = '0;
      status_n   = STAT_IDLE;
      hit_n      = '0;
      atk_n      = '0;
      ship_n     = '0;
    end else if (fire) begin
      unique case (state)
        ST_PLACE: begin
          // Starting the attack phase ignores the coordinate entirely.
          if (mode) begin
            if (ship_count != '0) begin
              state_n  = ST_ATTACK;
              status_n = STAT_IDLE;
            end else begin
              status_n = STAT_INVALID;
            end
          end else if (!coord_ok) begin
            status_n = STAT_INVALID;
          end else begin
            ship_map_n[coord_row][coord_col] = ~ship_map[coord_row][coord_col];
            if (ship_map[coord_row][coord_col])
              ship_n = ship_count - 1'b1;
            else
              ship_n = (ship_count == CELLS) ? ship_count : ship_count + 1'b1;
            status_n = STAT_PLACED;
          end
        end
        ST_ATTACK: begin
          if (mode) begin
            if (!coord_ok) begin
              status_n = STAT_INVALID;
            end else if (atk_map[coord_row][coord_col]) begin
              status_n = STAT_REPEAT;
            end else begin
              atk_map_n[coord_row][coord_col] = 1'b1;
              atk_n = (attack_count == CELLS) ? attack_count : attack_count + 1'b1;
              if (ship_map[coord_row][coord_col]) begin
                hit_n    = (hit_count == CELLS) ? hit_count : hit_count + 1'b1;
                status_n = STAT_HIT;
              end else begin
                status_n = STAT_MISS;
              end
              // Sinking the last ship wins even on the final allowed attack.
              if (hit_n == ship_count) begin
                state_n  = ST_OVER;
                status_n = STAT_WIN;
              end else if (atk_n == MAX_ATK) begin
                state_n  = ST_OVER;
                status_n = STAT_LOSE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row data is built from next-state values so it lines up with led_col.
  always_comb begin
    shown_n = ship_map_n;
    if (state_n == ST_ATTACK)
      shown_n = atk_map_n;
    else if (state_n == ST_OVER)
      shown_n = ship_map_n | atk_map_n;
    for (int r = 0; r < ROWS; r++)
      led_row_n[r] = shown_n[r][scan_col_n];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= ST_PLACE;
      ship_map     <= '0;
      atk_map      <= '0;
      status       <= STAT_IDLE;
      hit_count    <= '0;
      attack_count <= '0;
      ship_count   <= '0;
      confirm_prev <= 1'b0;
      led_row      <= '0;
    end else begin
      state        <= state_n;
      ship_map     <= ship_map_n;
      atk_map      <= atk_map_n;
      status       <= status_n;
      hit_count    <= hit_n;
      attack_count <= atk_n;
      ship_count   <= ship_n;
      confirm_prev <= btn_confirm;
      led_row      <= led_row_n;
    end
  end

endmodule

// File: tb/tb_battle_board_scan_ctrl.sv
// Bench for battle_board_scan_ctrl: directed vector table, hand-written scan and
// game-end sequences, and a randomized run against a board-level model.
module tb_battle_board_scan_ctrl;

  localparam int ROWS        = 5;
  localparam int COLS        = 7;
  localparam int SCAN_DIV    = 4;
  localparam int MAX_ATTACKS = 15;
  localparam int RW          = 3;
  localparam int CW          = 3;
  localparam int AW          = 6;

  localparam int S_IDLE = 0, S_PLACED = 1, S_HIT = 2, S_MISS = 3;
  localparam int S_REPEAT = 4, S_INVALID = 5, S_WIN = 6, S_LOSE = 7;

  logic            clk = 1'b0;
  logic            clr;
  logic            mode;
  logic [RW-1:0]   coord_row;
  logic [CW-1:0]   coord_col;
  logic            btn_confirm;
  logic            btn_clear;
  logic [ROWS-1:0] led_row;
  logic [COLS-1:0] led_col;
  logic [2:0]      status;
  logic [AW-1:0]   hit_count;
  logic [AW-1:0]   attack_count;
  logic [AW-1:0]   ship_count;
  logic            game_over;

  always #5 clk = ~clk;

  battle_board_scan_ctrl #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .SCAN_DIV    (SCAN_DIV),
    .MAX_ATTACKS (MAX_ATTACKS)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .mode         (mode),
    .coord_row    (coord_row),
    .coord_col    (coord_col),
    .btn_confirm  (btn_confirm),
    .btn_clear    (btn_clear),
    .led_row      (led_row),
    .led_col      (led_col),
    .status       (status),
    .hit_count    (hit_count),
    .attack_count (attack_count),
    .ship_count   (ship_count),
    .game_over    (game_over)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (board-level) ----------------
  bit m_ship [ROWS][COLS];
  bit m_atk  [ROWS][COLS];
  int m_phase;   // 0 placing, 1 attacking, 2 finished
  int m_status;
  int m_cyc;     // clock edges since reset; the scan column follows from it
  bit m_prev;

  function automatic int count_cells(input int which);
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if ((which == 0 && m_ship[r][c]) || (which == 1 && m_atk[r][c]) ||
            (which == 2 && m_ship[r][c] && m_atk[r][c]))
          n++;
    return n;
  endfunction

  task automatic model_clear_game();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_ship[r][c] = 1'b0;
        m_atk[r][c]  = 1'b0;
      end
    m_phase  = 0;
    m_status = S_IDLE;
  endtask

  task automatic model_reset();
    model_clear_game();
    m_cyc  = 0;
    m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit fire;
    bit ok;
    int r, c;
    fire   = btn_confirm && !m_prev;
    m_prev = btn_confirm;
    m_cyc++;
    r  = int'(coord_row);
    c  = int'(coord_col);
    ok = (r < ROWS) && (c < COLS);
    if (btn_clear) begin
      model_clear_game();
    end else if (fire) begin
      if (m_phase == 0) begin
        if (mode) begin
          if (count_cells(0) > 0) begin
            m_phase  = 1;
            m_status = S_IDLE;
          end else begin
            m_status = S_INVALID;
          end
        end else if (!ok) begin
          m_status = S_INVALID;
        end else begin
          m_ship[r][c] = !m_ship[r][c];
          m_status     = S_PLACED;
        end
      end else if (m_phase == 1 && mode) begin
        if (!ok) m_status = S_INVALID;
        else if (m_atk[r][c]) m_status = S_REPEAT;
        else begin
          m_atk[r][c] = 1'b1;
          m_status = m_ship[r][c] ? S_HIT : S_MISS;
          if (count_cells(2) == count_cells(0)) begin
            m_phase  = 2;
            m_status = S_WIN;
          end else if (count_cells(1) == MAX_ATTACKS) begin
            m_phase  = 2;
            m_status = S_LOSE;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int col;
    logic [ROWS-1:0] exp_row;
    logic [COLS-1:0] exp_col;
    col     = (m_cyc / SCAN_DIV) % COLS;
    exp_col = '0;
    exp_col[col] = 1'b1;
    for (int r = 0; r < ROWS; r++)
      exp_row[r] = (m_phase == 0) ? m_ship[r][col] :
                   (m_phase == 1) ? m_atk[r][col] : (m_ship[r][col] | m_atk[r][col]);
    chk("model.status",       32'(status),       32'(m_status));
    chk("model.ship_count",   32'(ship_count),   32'(count_cells(0)));
    chk("model.attack_count", 32'(attack_count), 32'(count_cells(1)));
    chk("model.hit_count",    32'(hit_count),    32'(count_cells(2)));
    chk("model.game_over",    32'(game_over),    32'(m_phase == 2));
    chk("model.led_col",      32'(led_col),      32'(exp_col));
    chk("model.led_row",      32'(led_row),      32'(exp_row));
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    if (clr) model_step();
    #1;
    check_model();
  endtask

  task automatic press(input bit m, input int r, input int c, input bit clear);
    @(negedge clk);
    mode        = m;
    coord_row   = RW'(r);
    coord_col   = CW'(c);
    btn_confirm = 1'b1;
    btn_clear   = clear;
    tick();
    @(negedge clk);
    btn_confirm = 1'b0;
    btn_clear   = 1'b0;
    tick();
  endtask

  typedef struct {
    bit mode;
    int row;
    int col;
    bit clear;
    int st;
    int ships;
    int hits;
    int atks;
    bit over;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    bit found;

    // mode,row,col,clear | status,ships,hits,attacks,over
    vecs[0]  = '{0, 0, 0, 0, S_PLACED,  1, 0, 0, 0};
    vecs[1]  = '{0, 4, 6, 0, S_PLACED,  2, 0, 0, 0};
    vecs[2]  = '{0, 4, 6, 0, S_PLACED,  1, 0, 0, 0};
    vecs[3]  = '{0, 2, 3, 0, S_PLACED,  2, 0, 0, 0};
    vecs[4]  = '{0, 5, 0, 0, S_INVALID, 2, 0, 0, 0};
    vecs[5]  = '{0, 0, 7, 0, S_INVALID, 2, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, S_IDLE,    2, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, S_HIT,     2, 1, 1, 0};
    vecs[8]  = '{1, 1, 1, 0, S_MISS,    2, 1, 2, 0};
    vecs[9]  = '{1, 0, 0, 0, S_REPEAT,  2, 1, 2, 0};
    vecs[10] = '{0, 3, 3, 0, S_REPEAT,  2, 1, 2, 0};
    vecs[11] = '{1, 5, 2, 0, S_INVALID, 2, 1, 2, 0};
    vecs[12] = '{1, 2, 3, 0, S_WIN,     2, 2, 3, 1};
    vecs[13] = '{1, 1, 2, 0, S_WIN,     2, 2, 3, 1};

    // ---------------- clock/reset ----------------
    clr = 1'b0; mode = 1'b0; coord_row = '0; coord_col = '0;
    btn_confirm = 1'b0; btn_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.status",    32'(status),       32'(S_IDLE));
    chk("reset.led_col",   32'(led_col),      32'(7'b0000001));
    chk("reset.led_row",   32'(led_row),      32'(0));
    chk("reset.counts",    32'(ship_count | hit_count | attack_count), 32'(0));
    chk("reset.game_over", 32'(game_over),    32'(0));
    clr = 1'b1;

    // ---------------- asynchronous reset in the middle of a scan ----------------
    found = 1'b0;
    for (int i = 0; i < COLS * SCAN_DIV + 4 && !found; i++) begin
      tick();
      if (led_col == 7'b0001000) found = 1'b1;
    end
    chk("scan.reach_col3", 32'(found), 32'(1));
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    model_reset();
    chk("scan.async_reset", 32'(led_col), 32'(7'b0000001));
    tick();
    @(negedge clk);
    clr = 1'b1;
    repeat (4) tick();
    chk("scan.after4", 32'(led_col), 32'(7'b0000010));
    repeat (24) tick();
    chk("scan.after28", 32'(led_col), 32'(7'b0000001));

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      press(vecs[i].mode, vecs[i].row, vecs[i].col, vecs[i].clear);
      chk($sformatf("vec%0d.status", i),       32'(status),       32'(vecs[i].st));
      chk($sformatf("vec%0d.ship_count", i),   32'(ship_count),   32'(vecs[i].ships));
      chk($sformatf("vec%0d.hit_count", i),    32'(hit_count),    32'(vecs[i].hits));
      chk($sformatf("vec%0d.attack_count", i), 32'(attack_count), 32'(vecs[i].atks));
      chk($sformatf("vec%0d.game_over", i),    32'(game_over),    32'(vecs[i].over));
    end

    // Finished board shows ships OR attacks: column 3 has only cell (2,3).
    found = 1'b0;
    for (int i = 0; i < COLS * SCAN_DIV + 4 && !found; i++) begin
      tick();
      if (led_col == 7'b0001000) found = 1'b1;
    end
    chk("over.reach_col3", 32'(found), 32'(1));
    chk("over.led_row_col3", 32'(led_row), 32'(5'b00100));

    // Clear beats a simultaneous confirm; then attack request with no ships.
    press(1, 0, 0, 1);
    chk("clear.status",    32'(status),     32'(S_IDLE));
    chk("clear.counts",    32'(ship_count | hit_count | attack_count), 32'(0));
    chk("clear.game_over", 32'(game_over),  32'(0));
    press(1, 0, 0, 0);
    chk("noships.status",  32'(status),     32'(S_INVALID));
    press(0, 0, 0, 0);
    chk("noships.still_place", 32'(status), 32'(S_PLACED));

    // Loss by running out of attacks with ships at (0,0) and (1,0).
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    for (int i = 0; i < MAX_ATTACKS; i++) begin
      press(1, 2 + i / COLS, i % COLS, 0);
      if (i < MAX_ATTACKS - 1) begin
        chk($sformatf("lose.miss%0d", i), 32'(status),    32'(S_MISS));
        chk($sformatf("lose.open%0d", i), 32'(game_over), 32'(0));
      end
    end
    chk("lose.status",       32'(status),       32'(S_LOSE));
    chk("lose.attack_count", 32'(attack_count), 32'(MAX_ATTACKS));
    chk("lose.game_over",    32'(game_over),    32'(1));
    press(1, 0, 0, 0);
    chk("lose.ignored",      32'(status),       32'(S_LOSE));
    press(0, 0, 0, 1);
    chk("lose.cleared",      32'(game_over | attack_count), 32'(0));

    // ---------------- randomized play ----------------
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) btn_confirm = ~btn_confirm;
      mode      = 1'($urandom_range(0, 1));
      coord_row = RW'($urandom_range(0, 5));
      coord_col = CW'($urandom_range(0, 7));
      btn_clear = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
